// File: rtl/lfsr_pack_pkg.sv
// ---------------------------------------------------------------------------
// lfsr_pack_pkg
// Shared types and constants for the TRNG bit packer slice.
//   pack_state_t      : packer FSM state (FILL accepting bits, FULL holding a
//                       completed word that could not be handed off yet)
//   RUN_CNT_W         : width of the repetition-count run length counter
//   DEFAULT_WIDTH     : default output word width
//   DEFAULT_RUN_LIMIT : default run length that trips the health test
//   sat_inc()         : saturating increment for the run length counter
// ---------------------------------------------------------------------------
package lfsr_pack_pkg;

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } pack_state_t;

    localparam int RUN_CNT_W         = 8;
    localparam int DEFAULT_WIDTH     = 32;
    localparam int DEFAULT_RUN_LIMIT = 34;

    function automatic logic [RUN_CNT_W-1:0] sat_inc(input logic [RUN_CNT_W-1:0] value);
        return (value == {RUN_CNT_W{1'b1}}) ? value : value + RUN_CNT_W'(1);
    endfunction

endpackage

// File: rtl/lfsr_rep_count.sv
// ---------------------------------------------------------------------------
// lfsr_rep_count
// Repetition-count health test on a qualified serial bit stream. Counts runs
// of identical consecutive bits and latches a sticky failure once a run
// reaches RUN_LIMIT. Only reset clears the failure.
// Ports:
//   clk         in  : clock, rising edge
//   rst         in  : synchronous active-high reset
//   bit_in      in  : serial bit
//   bit_strobe  in  : bit_in is consumed this cycle
//   health_fail out : sticky failure flag (registered)
// ---------------------------------------------------------------------------
module lfsr_rep_count
    import lfsr_pack_pkg::*;
#(
    parameter int RUN_LIMIT = DEFAULT_RUN_LIMIT
) (
    input  logic clk,
    input  logic rst,
    input  logic bit_in,
    input  logic bit_strobe,
    output logic health_fail
);

    logic                 last_bit_reg;
    logic                 seen_reg;       // at least one bit taken since reset
    logic [RUN_CNT_W-1:0] run_len_reg;
    logic [RUN_CNT_W-1:0] run_len_next;
    logic                 health_fail_reg;

    // The first bit after reset always starts a fresh run, regardless of the
    // reset value held in last_bit_reg.
    always_comb begin
        run_len_next = run_len_reg;
        if (bit_strobe) begin
            if (seen_reg && (bit_in == last_bit_reg)) begin
                run_len_next = sat_inc(run_len_reg);
            end else begin
                run_len_next = RUN_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_bit_reg    <= 1'b0;
            seen_reg        <= 1'b0;
            run_len_reg     <= '0;
            health_fail_reg <= 1'b0;
        end else if (bit_strobe) begin
            last_bit_reg <= bit_in;
            seen_reg     <= 1'b1;
            run_len_reg  <= run_len_next;
            if (run_len_next >= RUN_CNT_W'(RUN_LIMIT)) begin
                health_fail_reg <= 1'b1;
            end
        end
    end

    assign health_fail = health_fail_reg;

endmodule

// File: rtl/lfsr_bit_packer.sv
// ---------------------------------------------------------------------------
// lfsr_bit_packer
// Serial-to-parallel packer behind lfsr_filter. Accepts one bit per cycle
// under a valid/ready handshake, assembles WIDTH-bit words MSB first and
// offers them under a second valid/ready handshake. Buffering is one word in
// word_out plus one completed word held in the shift register (FULL state).
//
// Optional feature macro: LFSR_PACK_HEALTH_EN
//   defined   : repetition-count health test (lfsr_rep_count) is built in;
//               a failure blocks input, discards partial/held words and lets
//               an already valid word_out drain.
//   undefined : health_fail is tied low, no run tracking logic.
//
// Ports:
//   clk         in  : clock, rising edge
//   rst         in  : synchronous active-high reset
//   bit_in      in  : serial bit from lfsr_filter s_out
//   bit_valid   in  : bit_in valid
//   bit_ready   out : bit accepted this cycle (drives upstream en)
//   word_out    out : assembled word, first accepted bit in MSB
//   word_valid  out : word_out holds an unconsumed word
//   word_ready  in  : consumer takes word_out this cycle
//   health_fail out : sticky repetition-count failure
// ---------------------------------------------------------------------------
module lfsr_bit_packer
    import lfsr_pack_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int RUN_LIMIT = DEFAULT_RUN_LIMIT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_in,
    input  logic             bit_valid,
    output logic             bit_ready,
    output logic [WIDTH-1:0] word_out,
    output logic             word_valid,
    input  logic             word_ready,
    output logic             health_fail
);

    localparam int              CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(WIDTH);

    generate
        if (WIDTH < 2 || WIDTH > 128) begin : g_bad_width
            $error("lfsr_bit_packer: WIDTH must be in 2..128");
        end
        if (RUN_LIMIT < 2 || RUN_LIMIT > 255) begin : g_bad_run_limit
            $error("lfsr_bit_packer: RUN_LIMIT must be in 2..255");
        end
    endgenerate

    pack_state_t      state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [WIDTH-1:0] shreg_reg;
    logic [WIDTH-1:0] word_out_reg;
    logic             word_valid_reg;

    logic             accept;
    logic             slot_free;
    logic [WIDTH-1:0] shreg_shift;
    logic             load_word;
    logic [WIDTH-1:0] load_data;
    logic             health_fail_w;

`ifdef LFSR_PACK_HEALTH_EN
    lfsr_rep_count #(
        .RUN_LIMIT (RUN_LIMIT)
    ) u_rep_count (
        .clk         (clk),
        .rst         (rst),
        .bit_in      (bit_in),
        .bit_strobe  (accept),
        .health_fail (health_fail_w)
    );
`else
    assign health_fail_w = 1'b0;
`endif

    // bit_ready depends on registered state only, never on word_ready, so
    // there is no combinational path through the packer.
    assign bit_ready   = (state_reg == FILL) && !health_fail_w;
    assign accept      = bit_valid && bit_ready;
    assign slot_free   = !word_valid_reg || word_ready;
    assign shreg_shift = {shreg_reg[WIDTH-2:0], bit_in};

    // A word moves to word_out either straight from the shifter on the last
    // bit, or from the held shreg while in FULL.
    always_comb begin
        load_word = 1'b0;
        load_data = shreg_shift;
        if (!health_fail_w) begin
            case (state_reg)
                FILL: begin
                    load_word = accept && (cnt_reg == LAST_IDX) && slot_free;
                    load_data = shreg_shift;
                end
                FULL: begin
                    load_word = slot_free;
                    load_data = shreg_reg;
                end
                default: begin
                    load_word = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= FILL;
            cnt_reg        <= '0;
            shreg_reg      <= '0;
            word_out_reg   <= '0;
            word_valid_reg <= 1'b0;
        end else begin
            // Output slot: a load wins over a plain handshake, giving
            // back-to-back words with word_valid held high.
            if (load_word) begin
                word_out_reg   <= load_data;
                word_valid_reg <= 1'b1;
            end else if (word_ready) begin
                word_valid_reg <= 1'b0;
            end

            if (health_fail_w) begin
                // Partial word and any held word are dropped; input stays
                // blocked until reset.
                state_reg <= FILL;
                cnt_reg   <= '0;
                shreg_reg <= '0;
            end else begin
                case (state_reg)
                    FILL: begin
                        if (accept) begin
                            shreg_reg <= shreg_shift;
                            if (cnt_reg == LAST_IDX) begin
                                if (slot_free) begin
                                    cnt_reg <= '0;
                                end else begin
                                    cnt_reg   <= FULL_CNT;
                                    state_reg <= FULL;
                                end
                            end else begin
                                cnt_reg <= cnt_reg + CNT_W'(1);
                            end
                        end
                    end
                    FULL: begin
                        if (slot_free) begin
                            cnt_reg   <= '0;
                            state_reg <= FILL;
                        end
                    end
                    default: begin
                        state_reg <= FILL;
                        cnt_reg   <= '0;
                    end
                endcase
            end
        end
    end

    assign word_out    = word_out_reg;
    assign word_valid  = word_valid_reg;
    assign health_fail = health_fail_w;

endmodule

// File: doc/lfsr_bit_packer.md
# lfsr_bit_packer

Serial-to-parallel packer directly downstream of `lfsr_filter` in the TRNG datapath. It consumes the filter's one-bit `s_out` stream under a valid/ready handshake and assembles WIDTH-bit words, MSB first. It presents the words to the consumer (CSR/FIFO side) under a second valid/ready handshake. Optionally it runs a repetition-count health test on the raw bit stream and latches a sticky failure flag.

## Interface
Parameters:
- `WIDTH`, 32: output word width; legal range 2..128.
- `RUN_LIMIT`, 34: number of consecutive identical bits that trips the health test; legal range 2..255.

Ports:
- `clk`, in, 1: sole clock; all logic is on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `bit_in`, in, 1: serial bit, driven from `lfsr_filter` `s_out`.
- `bit_valid`, in, 1: `bit_in` is valid this cycle.
- `bit_ready`, out, 1: packer accepts a bit this cycle. Upstream `en` is driven from this signal.
- `word_out`, out, WIDTH: assembled word.
- `word_valid`, out, 1: `word_out` holds an unconsumed word.
- `word_ready`, in, 1: consumer takes `word_out` this cycle.
- `health_fail`, out, 1: sticky repetition-count failure.

## Operation
- A bit is accepted when `bit_valid && bit_ready`. On acceptance: `shreg <= {shreg[WIDTH-2:0], bit_in}` and `cnt <= cnt+1`. The first accepted bit of a word ends up in `word_out[WIDTH-1]`.
- `cnt` is $clog2(WIDTH+1) bits wide and counts 0..WIDTH.
- FSM states:
  - FILL (cnt < WIDTH): `bit_ready=1`.
  - FULL (cnt == WIDTH): `bit_ready=0`.
- The output slot is free when `!word_valid || word_ready`.
- Accepting the WIDTH-th bit while the slot is free: load `word_out` with the completed word, set `word_valid=1`, set `cnt=0`, stay in FILL.
- Accepting the WIDTH-th bit while the slot is not free: go to FULL and hold `shreg`.
- In FULL, when the slot frees: load `word_out` from `shreg`, set `word_valid=1`, set `cnt=0`, return to FILL.
- Handshake without a new load: `word_ready && word_valid` with no load that cycle clears `word_valid`.
- Handshake with a new load in the same cycle: `word_valid` stays 1 and `word_out` takes the new word (back-to-back words).
- `word_out` and `word_valid` must stay stable while `word_valid && !word_ready`.
- `bit_ready` is a function of FSM state (and `health_fail`) only. There is no combinational path from `word_ready` to `bit_ready`.
- Maximum buffering is one word in `word_out` plus one full word in `shreg`; no bit is ever dropped.

## Timing
- Reset values: `word_out=0`, `word_valid=0`, `bit_ready=1`, `health_fail=0`. Internal reset values: `cnt=0`, state FILL, `shreg=0`, run counter 0.
- A `rst` asserted mid-word discards the partial word and any held word, including a valid `word_out`.
- Latency: when the WIDTH-th bit is accepted at edge N, `word_valid` is high after edge N.
- From FULL, the word moves to `word_out` at the same edge at which `word_ready` frees the slot, and `bit_ready` returns to 1 after that edge.
- Throughput: one bit per cycle sustained when `word_ready` is held 1.

## Configuration
- `LFSR_PACK_HEALTH_EN` defined (repetition-count test compiled in):
  - Track the last accepted bit and an 8-bit saturating `run_len`.
  - On an accepted bit: if it equals the last bit and is not the first bit since reset, `run_len++`; otherwise `run_len=1`.
  - When `run_len` reaches RUN_LIMIT, `health_fail` goes to 1 after that edge and stays 1 until `rst`.
  - While `health_fail=1`: `bit_ready=0` and the partial word in `shreg` is discarded.
  - A `word_out` that was already valid still drains normally.
  - A word held in FULL at the moment of failure is discarded.
- `LFSR_PACK_HEALTH_EN` undefined: `health_fail` is tied to 0 and no run-tracking logic exists.

## Structure
- Package `lfsr_pack_pkg`:
  - state enum `pack_state_t` {FILL, FULL};
  - `RUN_CNT_W=8`;
  - default WIDTH and RUN_LIMIT constants.
- Sub-module `lfsr_rep_count`: the repetition-count tester. Inputs are `clk`, `rst`, `bit_in`, and a qualifying strobe; output is `health_fail`. It is instantiated only under `LFSR_PACK_HEALTH_EN`.

## Test plan
All scenarios use WIDTH=32 and RUN_LIMIT=34.
- Reset with `bit_valid=0` → `word_valid=0`, `bit_ready=1`, `word_out=0`, `health_fail=0`.
- 32 bits alternating 1,0 starting with 1, `word_ready=1` → `word_out=32'hAAAAAAAA`, with `word_valid` high the cycle after the 32nd bit and for exactly one cycle.
- `word_ready=0`, then 64 bits forming 32'h12345678 followed by 32'h9ABCDEF0 → `bit_ready` drops after the 64th bit. Raise `word_ready` → 32'h12345678 then 32'h9ABCDEF0 on consecutive cycles, then `bit_ready=1`.
- 10 bits, pulse `rst`, then 32 bits of 32'hDEADBEEF → `word_out=32'hDEADBEEF`; no residue from the pre-reset bits.
- 32'hCAFEF00D sent with random `bit_valid` gaps and random `word_ready` stalls → identical word; `word_out` stable throughout each stall.
- With `LFSR_PACK_HEALTH_EN`:
  - 33 ones then a 0 → `health_fail` stays 0.
  - 34 ones → `health_fail=1` after the 34th bit and `bit_ready=0` until `rst`.
  - Without the macro, 40 ones → `health_fail` stays 0.
